// File: rtl/addsub_seq_flags.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through a shared ripple slice,
// start/busy/done handshake, registered result and status flags.
module addsub_seq_flags #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    input  logic             k,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic [WIDTH-1:0] mag
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]       a_reg;
    logic [WIDTH-1:0]       b_reg;
    // Holds the chunks already produced; the final chunk comes straight from the slice.
    logic [WIDTH-CHUNK-1:0] sum_reg;
    logic                   carry;
    logic                   k_reg;
    logic [CW-1:0]          cnt;

    logic             accept;
    logic             last;
    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] neg_sum;
    logic             msb_carry;

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == CW'(N - 1));

    assign slice     = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    assign sum_next  = {slice[CHUNK-1:0], sum_reg};
    assign neg_sum   = (~sum_next) + WIDTH'(1);
    // Carry into the MSB recovered from the MSB's own sum bit and operand bits.
    assign msb_carry = a_reg[CHUNK-1] ^ b_reg[CHUNK-1] ^ slice[CHUNK-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            k_reg   <= 1'b0;
            cnt     <= '0;
            out     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
            mag     <= '0;
        end else if (accept) begin
            a_reg <= a_in;
            b_reg <= k ? ~b_in : b_in;
            carry <= cin;
            k_reg <= k;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg   <= a_reg >> CHUNK;
            b_reg   <= b_reg >> CHUNK;
            sum_reg <= sum_next[WIDTH-1:CHUNK];
            carry   <= slice[CHUNK];
            cnt     <= cnt + CW'(1);
            if (last) begin
                out  <= sum_next;
                cout <= slice[CHUNK];
                ovf  <= msb_carry ^ slice[CHUNK];
                zero <= (sum_next == '0);
                neg  <= sum_next[WIDTH-1];
                mag  <= (k_reg && sum_next[WIDTH-1]) ? neg_sum : sum_next;
            end
        end
    end
endmodule

// File: tb/tb_addsub_seq_flags.sv
// Bench for addsub_seq_flags: directed 8-bit vectors and handshake corners,
// plus a random 16-bit sweep against a reference model, via result scoreboards.
module tb_addsub_seq_flags;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start8, cin8, k8, busy8, done8, cout8, ovf8, zero8, neg8;
    logic [7:0] a8, b8, out8, mag8;
    logic        start16, cin16, k16, busy16, done16, cout16, ovf16, zero16, neg16;
    logic [15:0] a16, b16, out16, mag16;

    addsub_seq_flags #(.WIDTH(8), .CHUNK(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8), .k(k8),
        .busy(busy8), .done(done8), .out(out8), .cout(cout8), .ovf(ovf8), .zero(zero8),
        .neg(neg8), .mag(mag8)
    );

    addsub_seq_flags #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a_in(a16), .b_in(b16), .cin(cin16), .k(k16),
        .busy(busy16), .done(done16), .out(out16), .cout(cout16), .ovf(ovf16), .zero(zero16),
        .neg(neg16), .mag(mag16)
    );

    typedef struct {
        logic [7:0] a, b;
        logic       cin, k;
        logic [7:0] out;
        logic       cout, ovf, zero, neg;
        logic [7:0] mag;
    } vec8_t;

    typedef struct {
        logic [15:0] out;
        logic        cout, ovf, zero, neg;
        logic [15:0] mag;
    } res16_t;

    vec8_t  tbl[8];
    vec8_t  q8[$];
    res16_t q16[$];
    vec8_t  last8, e8, v;
    res16_t last16, e16;
    int     pass_cnt = 0;
    int     total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic res16_t ref16(input logic [15:0] a, input logic [15:0] b,
                                     input logic c, input logic kk);
        res16_t      r;
        logic [15:0] bb;
        logic [16:0] full;
        bb     = kk ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {16'd0, c};
        r.out  = full[15:0];
        r.cout = full[16];
        r.ovf  = (a[15] == bb[15]) && (r.out[15] != a[15]);
        r.zero = (r.out == 16'd0);
        r.neg  = r.out[15];
        r.mag  = (kk && r.neg) ? 16'(16'd0 - r.out) : r.out;
        return r;
    endfunction

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) chk("spurious_done8", 32'(1), 32'(0));
            else begin
                e8 = q8.pop_front();
                chk("out8", 32'(out8), 32'(e8.out));
                chk("cout8", 32'(cout8), 32'(e8.cout));
                chk("ovf8", 32'(ovf8), 32'(e8.ovf));
                chk("zero8", 32'(zero8), 32'(e8.zero));
                chk("neg8", 32'(neg8), 32'(e8.neg));
                chk("mag8", 32'(mag8), 32'(e8.mag));
                last8 = e8;
            end
        end
        if (done16) begin
            if (q16.size() == 0) chk("spurious_done16", 32'(1), 32'(0));
            else begin
                e16 = q16.pop_front();
                chk("out16", 32'(out16), 32'(e16.out));
                chk("cout16", 32'(cout16), 32'(e16.cout));
                chk("ovf16", 32'(ovf16), 32'(e16.ovf));
                chk("zero16", 32'(zero16), 32'(e16.zero));
                chk("neg16", 32'(neg16), 32'(e16.neg));
                chk("mag16", 32'(mag16), 32'(e16.mag));
                last16 = e16;
            end
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic op8(input vec8_t vv, input bit glitch);
        a8 = vv.a; b8 = vv.b; cin8 = vv.cin; k8 = vv.k; start8 = 1'b1;
        q8.push_back(vv);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); k8 = 1'($urandom);
        for (int i = 1; i <= 4; i++) begin
            chk("busy8_run", 32'(busy8), 32'(1));
            chk("done8_run", 32'(done8), 32'(0));
            chk("hold8", 32'(out8), 32'(last8.out));
            if (glitch) start8 = (i == 2);
            @(negedge clk);
        end
        chk("done8_lat", 32'(done8), 32'(1));
        chk("busy8_done", 32'(busy8), 32'(0));
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic kk);
        a16 = a; b16 = b; cin16 = c; k16 = kk; start16 = 1'b1;
        q16.push_back(ref16(a, b, c, kk));
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); k16 = 1'($urandom);
        for (int i = 1; i <= 4; i++) begin
            chk("busy16_run", 32'(busy16), 32'(1));
            chk("hold16", 32'(out16), 32'(last16.out));
            @(negedge clk);
        end
        chk("done16_lat", 32'(done16), 32'(1));
    endtask

    initial begin
        tbl[0] = '{8'd100, 8'd27,  1'b0, 1'b0, 8'd127,  1'b0, 1'b0, 1'b0, 1'b0, 8'd127};
        tbl[1] = '{8'd200, 8'd100, 1'b0, 1'b0, 8'd44,   1'b1, 1'b0, 1'b0, 1'b0, 8'd44};
        tbl[2] = '{8'd100, 8'd50,  1'b1, 1'b0, 8'd151,  1'b0, 1'b1, 1'b0, 1'b1, 8'd151};
        tbl[3] = '{8'd5,   8'd9,   1'b1, 1'b1, 8'hFC,   1'b0, 1'b0, 1'b0, 1'b1, 8'd4};
        tbl[4] = '{8'd7,   8'd7,   1'b1, 1'b1, 8'h00,   1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[5] = '{8'h80,  8'h01,  1'b1, 1'b1, 8'h7F,   1'b1, 1'b1, 1'b0, 1'b0, 8'h7F};
        tbl[6] = '{8'h00,  8'h80,  1'b1, 1'b1, 8'h80,   1'b0, 1'b1, 1'b0, 1'b1, 8'h80};
        tbl[7] = '{8'hFF,  8'h01,  1'b0, 1'b0, 8'h00,   1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        last8  = '{8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        last16 = '{16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

        rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; k8 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0; k16 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy8", 32'(busy8), 32'(0));
        chk("rst_done8", 32'(done8), 32'(0));
        chk("rst_out8", 32'(out8), 32'(0));
        chk("rst_flags8", 32'({cout8, ovf8, zero8, neg8}), 32'(0));
        chk("rst_mag8", 32'(mag8), 32'(0));
        chk("rst_busy16", 32'(busy16), 32'(0));

        for (int i = 0; i < 8; i++) begin
            op8(tbl[i], 1'b0);
            @(negedge clk);
        end

        // Second start lands in the done cycle of the first.
        op8(tbl[0], 1'b0);
        op8(tbl[5], 1'b0);
        @(negedge clk);

        // Start pulsed mid-run must be ignored.
        op8(tbl[1], 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_extra_done8", 32'(done8), 32'(0));
        end

        // Reset two cycles into a run aborts it.
        a8 = 8'd55; b8 = 8'd66; cin8 = 1'b0; k8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy8", 32'(busy8), 32'(0));
        chk("abort_done8", 32'(done8), 32'(0));
        chk("abort_out8", 32'(out8), 32'(0));
        chk("abort_flags8", 32'({cout8, ovf8, zero8, neg8}), 32'(0));
        chk("abort_mag8", 32'(mag8), 32'(0));
        last8.out = 8'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done8", 32'(done8), 32'(0));
        end
        v = '{8'd3, 8'd4, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7};
        op8(v, 1'b0);
        @(negedge clk);

        for (int n = 0; n < 1000; n++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("q8_drained", 32'(q8.size()), 32'(0));
        chk("q16_drained", 32'(q16.size()), 32'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/addsub_seq_flags.md
Name: addsub_seq_flags

Overview:
- Parametrised, multi-cycle adder/subtractor: next generation of the team's 4-bit combinational add/sub.
- Processes the operands CHUNK bits per clock, LSB first, through a shared CHUNK-bit ripple slice.
- Uses a start/busy/done handshake and produces registered result, carry and status flags.
- Sits between a control sequencer and the register file wherever area matters more than single-cycle latency.

Parameters:
- WIDTH, 8, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 2, bits processed per clock; number of RUN cycles N = WIDTH/CHUNK.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request pulse; sampled only when the block is not busy.
- a_in  input  WIDTH  operand A, latched on an accepted start.
- b_in  input  WIDTH  operand B, latched on an accepted start.
- cin  input  1  carry-in, latched on an accepted start.
- k  input  1  mode, latched on an accepted start: 0 = add, 1 = subtract.
- busy  output  1  high while the operation runs.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- out  output  WIDTH  result, two's-complement encoded.
- cout  output  1  final carry out of the MSB (for k=1 this is the not-borrow bit).
- ovf  output  1  signed overflow.
- zero  output  1  high when out == 0.
- neg  output  1  out[WIDTH-1].
- mag  output  WIDTH  magnitude: the two's-complement negation of out when k=1 and neg=1, otherwise out.

Behaviour:
- Reset: rst_n is synchronous and active-low. While rst_n=0 at a rising edge:
  - state goes to IDLE;
  - busy, done, out, cout, ovf, zero, neg, mag and all internal registers go to 0.
  - Reset mid-operation aborts the operation; no done is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches the operands.
  - Operand B is stored as b_in when k=0 and as ~b_in when k=1.
  - Carry register is loaded with cin in both modes, so k=1 with cin=1 gives a-b.
  - Cycle counter is cleared to 0; next state is RUN.
- RUN:
  - busy=1.
  - Each cycle adds the low CHUNK bits of A and B plus the carry.
  - The CHUNK sum bits shift into the top of the result shift register; A and B shift right by CHUNK.
  - The carry register updates with the slice carry.
  - On the last chunk (counter == N-1), capture the carry into bit WIDTH-1 of the sum, for overflow; next state is DONE.
  - start is ignored while in RUN.
- DONE:
  - Lasts one cycle, with busy=0 and done=1.
  - out, cout, ovf, zero, neg and mag were registered at the edge entering DONE and are valid now.
  - ovf = (carry into MSB) xor cout.
  - start=1 in the DONE cycle is accepted exactly as in IDLE (back-to-back, next state RUN); otherwise next state is IDLE.
- Latency:
  - start sampled at edge t: busy is high for cycles t+1 .. t+N, and done is high in cycle t+N+1.
  - Throughput is one operation per N+1 cycles.
- Outputs out, cout, ovf, zero, neg and mag hold their values until the next operation's DONE entry or reset. They do not change during RUN.
- Width rules:
  - All arithmetic is modulo 2^WIDTH; no saturation.
  - mag of the most negative value (0x80 for WIDTH=8) is 0x80.
- Inputs a_in, b_in, cin and k may change freely after acceptance without affecting the running operation.

Test Plan:
- Add, WIDTH=8, CHUNK=2: a=100, b=27, cin=0, k=0 -> out=127, cout=0, ovf=0, zero=0, neg=0; done exactly 5 cycles after the start edge; busy high for 4 cycles.
- Add with carry: a=200, b=100, cin=0, k=0 -> out=44, cout=1, ovf=0. Then a=100, b=50, cin=1 -> out=151, ovf=1, neg=1, cout=0.
- Subtract negative result: a=5, b=9, cin=1, k=1 -> out=0xFC, cout=0, neg=1, mag=4, ovf=0. Also a=7, b=7 -> out=0, zero=1, cout=1.
- Signed overflow on subtract: a=0x80, b=0x01, cin=1, k=1 -> out=0x7F, ovf=1, cout=1, neg=0, mag=0x7F.
- Handshake:
  - start pulsed again during RUN -> ignored; exactly one done, with the first operation's results.
  - start asserted in the done cycle -> second operation completes N+1 cycles later with correct results.
- Reset and parameter sweep:
  - rst_n=0 for one edge during RUN -> busy, done and all outputs 0 next cycle; no done appears.
  - Subsequent op a=3, b=4, k=0 -> out=7.
  - Repeat with WIDTH=16, CHUNK=4 over 1000 random operands and modes against a reference model; done latency is 5 cycles.
